// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler
//   Sequencing controller for the QED instruction transformer. It counts
//   originals issued in a sequence, then switches the transformer to its
//   duplicate phase (exec_dup) and counts duplicates. When every original
//   has been matched by a duplicate, it spends one CHECK cycle with
//   qed_ready and hold_IF asserted. That cycle is the consistency check point.
//   dup_req is a free "start duplicates now" choice; it is honoured only
//   when at least one original exists.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   ena        in   global enable; 0 freezes state, counters, exec_dup, hold_IF
//   stall_IF   in   fetch stall; suppresses issue counting
//   vld_out    in   transformer output valid
//   dup_req    in   request to end the original phase early
//   exec_dup   out  registered; transformer emits duplicates
//   hold_IF    out  registered; fetch hold during CHECK
//   qed_ready  out  registered one-cycle pulse at sequence completion
//   orig_cnt   out  originals issued in the current sequence
//   dup_cnt    out  duplicates issued in the current sequence
module qed_dup_scheduler #(
  parameter int MAX_ORIG = 4,
  parameter int CNT_W    = $clog2(MAX_ORIG + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ena,
  input  logic             stall_IF,
  input  logic             vld_out,
  input  logic             dup_req,
  output logic             exec_dup,
  output logic             hold_IF,
  output logic             qed_ready,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt
);

  typedef enum logic [1:0] {IDLE, ORIG, DUP, CHECK} state_t;

  // One extra bit so the "+ issue" sums can never wrap before comparison.
  localparam int SUM_W = CNT_W + 1;

  state_t           state_reg, state_next;
  logic             exec_dup_reg, exec_dup_next;
  logic             hold_reg, hold_next;
  logic             ready_reg, ready_next;
  logic [CNT_W-1:0] orig_reg, orig_next;
  logic [CNT_W-1:0] dup_reg, dup_next;

  logic             issue;
  logic             orig_full;
  logic [SUM_W-1:0] orig_sum;
  logic [SUM_W-1:0] dup_sum;

  assign issue = ena & vld_out & ~stall_IF;

  // orig_cnt can only already be at MAX_ORIG on entry to ORIG when an issue
  // leaked through CHECK with MAX_ORIG==1; further issues are then dropped
  // so the counter never exceeds its ceiling.
  assign orig_full = (orig_reg == CNT_W'(MAX_ORIG));
  assign orig_sum  = orig_full ? {1'b0, orig_reg}
                               : ({1'b0, orig_reg} + SUM_W'(issue));
  assign dup_sum   = {1'b0, dup_reg} + SUM_W'(issue);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      exec_dup_reg <= 1'b0;
      hold_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      orig_reg     <= '0;
      dup_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      exec_dup_reg <= exec_dup_next;
      hold_reg     <= hold_next;
      ready_reg    <= ready_next;
      orig_reg     <= orig_next;
      dup_reg      <= dup_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    exec_dup_next = exec_dup_reg;
    hold_next     = hold_reg;
    ready_next    = 1'b0;          // qed_ready is a pulse; also cleared when ena=0
    orig_next     = orig_reg;
    dup_next      = dup_reg;

    if (ena) begin
      case (state_reg)
        IDLE: begin
          // The issue in this cycle is intentionally not counted.
          state_next    = ORIG;
          exec_dup_next = 1'b0;
          hold_next     = 1'b0;
        end
        ORIG: begin
          exec_dup_next = 1'b0;
          orig_next     = orig_sum[CNT_W-1:0];
          if ((orig_sum == SUM_W'(MAX_ORIG)) ||
              (dup_req && (orig_sum != '0))) begin
            state_next    = DUP;
            exec_dup_next = 1'b1;
          end
        end
        DUP: begin
          dup_next = dup_sum[CNT_W-1:0];
          if (dup_sum == {1'b0, orig_reg}) begin
            state_next    = CHECK;
            exec_dup_next = 1'b0;
            hold_next     = 1'b1;
            ready_next    = 1'b1;
          end
        end
        CHECK: begin
          // An issue leaking through the hold is the first original of
          // the next sequence.
          state_next = ORIG;
          hold_next  = 1'b0;
          dup_next   = '0;
          orig_next  = CNT_W'(issue);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign exec_dup  = exec_dup_reg;
  assign hold_IF   = hold_reg;
  assign qed_ready = ready_reg;
  assign orig_cnt  = orig_reg;
  assign dup_cnt   = dup_reg;

endmodule
